demux1xn_stream: RTL and testbench

DEMUX1XN_STREAM -- requirements
Module: demux1xn_stream

---
 rtl/demux_pkg.sv | 21 ++
 rtl/demux_chan_buf.sv | 41 ++++
 rtl/demux1xn_stream.sv | 86 ++++++++
 tb/tb_demux1xn_stream.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared definitions for the 1xN stream demultiplexer.
//   DROP_CNT_W : width of the saturating dropped-word counter.
//   clog2()    : ceiling log2, usable in parameter expressions.
package demux_pkg;

  localparam int unsigned DROP_CNT_W = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (value == 0) ? 0 : value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// demux_chan_buf
//   Single-entry buffer for one output channel.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears flag and data
//   load      : capture load_data (wins over drain when both asserted)
//   load_data : word to capture
//   drain     : consumer took the held word this cycle
//   full      : buffer holds a word
//   data      : held word
module demux_chan_buf #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (load) begin
      // A load in the same cycle as a drain replaces the outgoing word.
      r_full <= 1'b1;
      r_data <= load_data;
    end else if (drain) begin
      r_full <= 1'b0;
    end
  end

  assign full = r_full;
  assign data = r_data;

endmodule

// File: rtl/demux1xn_stream.sv
// demux1xn_stream
//   Routes a valid/ready input stream to one of N output channels, each
//   backed by a single-entry buffer. Words addressed to a non-existent
//   channel are accepted, discarded and counted.
//   clk, rst   : clock and synchronous active-high reset
//   in_data    : input word
//   in_sel     : destination channel index
//   in_valid   : producer offers a word
//   in_ready   : offer accepted this cycle (independent of in_valid)
//   out_data   : packed channel words, channel k at [k*WIDTH +: WIDTH],
//                zero when that channel is empty
//   out_valid  : per-channel full flag
//   out_ready  : per-channel consumer accept
//   drop_cnt   : saturating count of out-of-range words
module demux1xn_stream
  import demux_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  parameter  int unsigned N     = 2,
  localparam int unsigned SEL_W = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N*WIDTH-1:0]    out_data,
  output logic [N-1:0]          out_valid,
  input  logic [N-1:0]          out_ready,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [N-1:0]            w_hit;
  logic [N-1:0]            w_load;
  logic [N-1:0]            w_drain;
  logic [N-1:0]            w_full;
  logic [WIDTH-1:0]        w_data [N];
  logic                    w_drop;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;

  // Select decode and ready mux; an index with no matching channel
  // leaves in_ready at 1 so the word can be dropped.
  always_comb begin
    w_hit    = '0;
    in_ready = 1'b1;
    for (int unsigned k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        w_hit[k] = 1'b1;
        in_ready = !w_full[k] || out_ready[k];
      end
    end
  end

  assign w_load  = {N{in_valid && in_ready}} & w_hit;
  assign w_drain = w_full & out_ready;
  assign w_drop  = in_valid && !(|w_hit);

  for (genvar k = 0; k < N; k++) begin : g_chan
    demux_chan_buf #(
      .WIDTH(WIDTH)
    ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load[k]),
      .load_data(in_data),
      .drain    (w_drain[k]),
      .full     (w_full[k]),
      .data     (w_data[k])
    );
    assign out_data[k*WIDTH +: WIDTH] = w_full[k] ? w_data[k] : '0;
  end

  assign out_valid = w_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux1xn_stream.sv
// tb_demux1xn_stream
//   Three instances share clock and reset: index 0 is N=2, index 1 is N=3,
//   index 2 is N=4, all WIDTH=4. A per-channel queue model predicts
//   readiness, held words, emitted words and the drop count.
module tb_demux1xn_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] d    [3];
  logic [1:0] s    [3];
  logic       v    [3];
  logic [3:0] ordy [3];

  logic        r2, r3, r4;
  logic [1:0]  ov2;
  logic [2:0]  ov3;
  logic [3:0]  ov4;
  logic [7:0]  od2;
  logic [11:0] od3;
  logic [15:0] od4;
  logic [7:0]  dc2, dc3, dc4;

  logic        irdy [3];
  logic [3:0]  ov   [3];
  logic [15:0] od   [3];
  logic [7:0]  dc   [3];

  always_comb begin
    irdy[0] = r2;  irdy[1] = r3;  irdy[2] = r4;
    ov[0]   = {2'b0, ov2};
    ov[1]   = {1'b0, ov3};
    ov[2]   = ov4;
    od[0]   = {8'h0, od2};
    od[1]   = {4'h0, od3};
    od[2]   = od4;
    dc[0]   = dc2; dc[1] = dc3; dc[2] = dc4;
  end

  demux1xn_stream #(.WIDTH(4), .N(2)) u_n2 (
    .clk(clk), .rst(rst), .in_data(d[0]), .in_sel(s[0][0:0]), .in_valid(v[0]),
    .in_ready(r2), .out_data(od2), .out_valid(ov2), .out_ready(ordy[0][1:0]),
    .drop_cnt(dc2)
  );

  demux1xn_stream #(.WIDTH(4), .N(3)) u_n3 (
    .clk(clk), .rst(rst), .in_data(d[1]), .in_sel(s[1]), .in_valid(v[1]),
    .in_ready(r3), .out_data(od3), .out_valid(ov3), .out_ready(ordy[1][2:0]),
    .drop_cnt(dc3)
  );

  demux1xn_stream #(.WIDTH(4), .N(4)) u_n4 (
    .clk(clk), .rst(rst), .in_data(d[2]), .in_sel(s[2]), .in_valid(v[2]),
    .in_ready(r4), .out_data(od4), .out_valid(ov4), .out_ready(ordy[2]),
    .drop_cnt(dc4)
  );

  logic [3:0] q [12][$];
  int         edrop [3];
  int         nvec  = 0;
  int         nfail = 0;

  function automatic int nch(input int i);
    return i + 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called with inputs already driven; checks pre-edge readiness and
  // emitted words, advances the model, then checks registered state.
  task automatic tick();
    logic [3:0]  evld;
    logic [15:0] edat;
    logic        er;
    int          sel;
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = (i == 0) ? int'(s[0][0]) : int'(s[i]);
      er  = (sel >= nch(i)) ? 1'b1 : ((q[i*4+sel].size() == 0) || ordy[i][sel]);
      chk($sformatf("in_ready[%0d]", i), 32'(irdy[i]), 32'(er));
      if (!rst) begin
        for (int k = 0; k < nch(i); k++) begin
          if (q[i*4+k].size() != 0 && ordy[i][k])
            chk($sformatf("emit[%0d][%0d]", i, k), 32'(od[i][k*4 +: 4]), 32'(q[i*4+k].pop_front()));
        end
        if (v[i] && er) begin
          if (sel < nch(i)) q[i*4+sel].push_back(d[i]);
          else if (edrop[i] < 255) edrop[i]++;
        end
      end
    end
    if (rst) begin
      for (int j = 0; j < 12; j++) q[j].delete();
      for (int i = 0; i < 3; i++) edrop[i] = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      evld = '0;
      edat = '0;
      for (int k = 0; k < nch(i); k++) begin
        if (q[i*4+k].size() != 0) begin
          evld[k]         = 1'b1;
          edat[k*4 +: 4]  = q[i*4+k][0];
        end
      end
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(evld));
      chk($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(edat));
      chk($sformatf("drop_cnt[%0d]", i), 32'(dc[i]), 32'(edrop[i]));
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d[i] = '0; s[i] = '0; v[i] = 1'b0; ordy[i] = '0; edrop[i] = 0;
    end

    // Reset held two cycles.
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Routing on N=2: word to channel 1, second word stalls until drained.
    s[0] = 2'd1; d[0] = 4'hA; v[0] = 1'b1;
    tick();
    d[0] = 4'hB;
    tick();
    tick();
    ordy[0] = 4'b0010;
    tick();
    v[0] = 1'b0;
    tick();
    ordy[0] = '0;
    tick();

    // Back-to-back on N=4 channel 2 with consumer always ready.
    ordy[2] = 4'hF; s[2] = 2'd2; v[2] = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      d[2] = 4'(w);
      tick();
    end
    v[2] = 1'b0;
    tick();
    tick();
    ordy[2] = '0;

    // Concurrency on N=2: channel 0 stalled while channel 1 is loaded.
    s[0] = 2'd0; d[0] = 4'h3; v[0] = 1'b1;
    tick();
    s[0] = 2'd1; d[0] = 4'h5;
    tick();
    s[0] = 2'd0; d[0] = 4'hE;
    tick();
    v[0] = 1'b0;
    tick();
    ordy[0] = 4'b0011;
    tick();
    tick();
    ordy[0] = '0;

    // Out-of-range select on N=3: drop counter saturates at 255.
    s[1] = 2'd3; d[1] = 4'h7; v[1] = 1'b1;
    for (int c = 0; c < 300; c++) tick();
    s[1] = 2'd2; d[1] = 4'h6;
    tick();
    v[1] = 1'b0; ordy[1] = 4'b0100;
    tick();
    ordy[1] = '0;

    // Reset mid-operation discards held words.
    s[0] = 2'd0; d[0] = 4'h7; v[0] = 1'b1;
    tick();
    s[0] = 2'd1; d[0] = 4'h9;
    tick();
    v[0] = 1'b0; rst = 1'b1; ordy[0] = 4'b0011;
    tick();
    rst = 1'b0;
    tick();
    ordy[0] = '0;

    // Mixed traffic on N=3 and N=4 including drain/refill overlap.
    for (int c = 0; c < 200; c++) begin
      v[1]    = 1'($urandom_range(0, 1));
      s[1]    = 2'($urandom_range(0, 3));
      d[1]    = 4'($urandom);
      ordy[1] = 4'($urandom) & 4'h7;
      v[2]    = 1'($urandom_range(0, 1));
      s[2]    = 2'($urandom_range(0, 3));
      d[2]    = 4'($urandom);
      ordy[2] = 4'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
